// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM states, LFSR tap masks and counter sizing for the PUF CRP engine
package puf_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_LAUNCH, ST_SETTLE, ST_SAMPLE, ST_EMIT, ST_DONE
  } state_e;
  function automatic logic [127:0] lfsr_taps(input int n);
    logic [127:0] t;
    t = '0;
    case (n)
      32: begin t[31] = 1'b1; t[21] = 1'b1; t[1] = 1'b1; t[0] = 1'b1; end
      64: begin t[63] = 1'b1; t[62] = 1'b1; t[60] = 1'b1; t[59] = 1'b1; end
      128: begin t[127] = 1'b1; t[125] = 1'b1; t[100] = 1'b1; t[98] = 1'b1; end
      default: t = '0;
    endcase
    return t;
  endfunction
  function automatic int cnt_w(input int nchal, input int reps);
    return $clog2(nchal * reps + 1);
  endfunction
endpackage

// File: rtl/puf_crp_engine_lfsr.sv
// lfsr_chal_gen: Fibonacci shift-left challenge generator, reloadable to its seed
module lfsr_chal_gen
  import puf_pkg::*;
#(
  parameter int N = 64,
  parameter logic [N-1:0] SEED = N'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  output logic [N-1:0] chal
);
  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));
  localparam logic [N-1:0] S0 = (SEED == '0) ? N'(1) : SEED;
  if (!(N == 32 || N == 64 || N == 128)) begin : g_bad_n
    $error("lfsr_chal_gen: N must be 32, 64 or 128");
  end
  logic [N-1:0] s_q, s_d;
  always_comb s_d = load ? S0 : adv ? {s_q[N-2:0], ^(s_q & TAPS)} : s_q;
  always_ff @(posedge clk)
    if (rst) s_q <= S0;
    else s_q <= s_d;
  assign chal = s_q;
endmodule

// File: rtl/puf_crp_engine.sv
// puf_crp_engine: launches LFSR challenges at arbiter PUFs, majority-votes repeated samples,
// streams CRPs over valid/ready and accumulates uniformity/reliability/uniqueness counters
module puf_crp_engine
  import puf_pkg::*;
#(
  parameter int N = 64,
  parameter int NUM_CH = 2,
  parameter int NUM_CHAL = 512,
  parameter int REPEATS = 5,
  parameter int LAUNCH_W = 1,
  parameter int SETTLE = 4,
  parameter logic [N-1:0] SEED = N'(1),
  localparam int CW = cnt_w(NUM_CHAL, REPEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 puf_launch,
  output logic [N-1:0]         puf_chal,
  input  logic [NUM_CH-1:0]    puf_resp,
  output logic                 crp_valid,
  input  logic                 crp_ready,
  output logic [N-1:0]         crp_chal,
  output logic [NUM_CH-1:0]    crp_resp,
  output logic [NUM_CH-1:0]    crp_unstable,
  output logic [NUM_CH*CW-1:0] ones_cnt,
  output logic [NUM_CH*CW-1:0] stable_cnt,
  output logic [NUM_CH*CW-1:0] diff_cnt
);
  localparam int VW = $clog2(REPEATS + 1);
  localparam int TW = $clog2(LAUNCH_W + SETTLE + 1);
  localparam int HW = $clog2(NUM_CHAL + 1);
  state_e state_q, state_d;
  logic [TW-1:0] cyc_q, cyc_d;
  logic [VW-1:0] rep_q, rep_d;
  logic [HW-1:0] idx_q, idx_d;
  logic [NUM_CH-1:0] meta_q, sync_q, first_q, first_d, resp;
  logic [VW-1:0] votes_q [NUM_CH];
  logic [VW-1:0] votes_d [NUM_CH];
  logic [CW-1:0] ones_q [NUM_CH];
  logic [CW-1:0] ones_d [NUM_CH];
  logic [CW-1:0] stable_q [NUM_CH];
  logic [CW-1:0] stable_d [NUM_CH];
  logic [CW-1:0] diff_q [NUM_CH];
  logic [CW-1:0] diff_d [NUM_CH];
  logic [N-1:0] chal_q, chal_d;
  logic go, last_rep, adv;
  assign go = state_q == ST_IDLE && start;
  assign last_rep = rep_q == VW'(REPEATS - 1);
  assign adv = state_q == ST_SAMPLE && last_rep;
  lfsr_chal_gen #(.N(N), .SEED(SEED)) u_lfsr (
    .clk(clk), .rst(rst), .load(go), .adv(adv), .chal(puf_chal)
  );
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign resp[k] = int'(votes_q[k]) * 2 > REPEATS;
    assign crp_unstable[k] = votes_q[k] != '0 && votes_q[k] != VW'(REPEATS);
    assign ones_cnt[k*CW +: CW] = ones_q[k];
    assign stable_cnt[k*CW +: CW] = stable_q[k];
    assign diff_cnt[k*CW +: CW] = diff_q[k];
  end
  assign busy = state_q != ST_IDLE && state_q != ST_DONE;
  assign done = state_q == ST_DONE;
  assign puf_launch = state_q == ST_LAUNCH;
  assign crp_valid = state_q == ST_EMIT;
  assign crp_chal = chal_q;
  assign crp_resp = resp;
  always_comb begin
    state_d = state_q;
    cyc_d = cyc_q;
    rep_d = rep_q;
    idx_d = idx_q;
    first_d = first_q;
    chal_d = chal_q;
    votes_d = votes_q;
    ones_d = ones_q;
    stable_d = stable_q;
    diff_d = diff_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_PRE;
        rep_d = '0;
        idx_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
          votes_d[k] = '0;
          ones_d[k] = '0;
          stable_d[k] = '0;
          diff_d[k] = '0;
        end
      end
      ST_PRE: begin
        state_d = ST_LAUNCH;
        cyc_d = '0;
      end
      ST_LAUNCH: begin
        state_d = cyc_q == TW'(LAUNCH_W - 1) ? ST_SETTLE : ST_LAUNCH;
        cyc_d = cyc_q == TW'(LAUNCH_W - 1) ? '0 : cyc_q + TW'(1);
      end
      ST_SETTLE: begin
        state_d = cyc_q == TW'(SETTLE - 1) ? ST_SAMPLE : ST_SETTLE;
        cyc_d = cyc_q + TW'(1);
      end
      ST_SAMPLE: begin
        // repeat 0 is the reference each later repeat is scored against
        for (int k = 0; k < NUM_CH; k++) begin
          votes_d[k] = votes_q[k] + VW'(sync_q[k]);
          if (rep_q != '0 && sync_q[k] == first_q[k]) stable_d[k] = stable_q[k] + CW'(1);
        end
        first_d = rep_q == '0 ? sync_q : first_q;
        state_d = last_rep ? ST_EMIT : ST_PRE;
        rep_d = last_rep ? '0 : rep_q + VW'(1);
        chal_d = last_rep ? puf_chal : chal_q;
      end
      ST_EMIT: if (crp_ready) begin
        for (int k = 0; k < NUM_CH; k++) begin
          ones_d[k] = ones_q[k] + CW'(resp[k]);
          diff_d[k] = diff_q[k] + CW'(resp[k] ^ resp[0]);
          votes_d[k] = '0;
        end
        state_d = idx_q == HW'(NUM_CHAL - 1) ? ST_DONE : ST_PRE;
        idx_d = idx_q + HW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q <= '0;
      rep_q <= '0;
      idx_q <= '0;
      meta_q <= '0;
      sync_q <= '0;
      first_q <= '0;
      chal_q <= '0;
      votes_q <= '{default: '0};
      ones_q <= '{default: '0};
      stable_q <= '{default: '0};
      diff_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      rep_q <= rep_d;
      idx_q <= idx_d;
      meta_q <= puf_resp;
      sync_q <= meta_q;
      first_q <= first_d;
      chal_q <= chal_d;
      votes_q <= votes_d;
      ones_q <= ones_d;
      stable_q <= stable_d;
      diff_q <= diff_d;
    end
  end
endmodule

// File: tb/tb_puf_crp_engine.sv
// tb_puf_crp_engine: behavioural PUF stubs, CRP scoreboard and table-driven runs for puf_crp_engine
module tb_puf_crp_engine;
  localparam int N = 64, NC = 2, NCH = 8, REP = 5, LW = 1, ST = 4;
  localparam int CW = $clog2(NCH * REP + 1);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, crp_ready = 1'b1;
  logic busy, done, puf_launch, crp_valid;
  logic [N-1:0] puf_chal, crp_chal;
  logic [NC-1:0] puf_resp = '0, crp_resp, crp_unstable;
  logic [NC*CW-1:0] ones_cnt, stable_cnt, diff_cnt;
  always #5 clk = ~clk;
  puf_crp_engine #(
    .N(N), .NUM_CH(NC), .NUM_CHAL(NCH), .REPEATS(REP), .LAUNCH_W(LW), .SETTLE(ST), .SEED(N'(1))
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .puf_launch(puf_launch),
    .puf_chal(puf_chal), .puf_resp(puf_resp), .crp_valid(crp_valid), .crp_ready(crp_ready),
    .crp_chal(crp_chal), .crp_resp(crp_resp), .crp_unstable(crp_unstable),
    .ones_cnt(ones_cnt), .stable_cnt(stable_cnt), .diff_cnt(diff_cnt)
  );
  typedef struct {
    logic [N-1:0] chal;
    logic [NC-1:0] resp;
    logic [NC-1:0] unst;
  } crp_t;
  typedef struct {
    int mode;
    int rdy;
    int ones0, ones1, stab0, stab1, diff0, diff1;
  } vec_t;
  crp_t q[$];
  crp_t cm, ce;
  vec_t vt[4];
  int tests = 0, fails = 0;
  int mode = 0, launches = 0, rep_m = 0, n_crp = 0, done_cnt = 0, vm = 0;
  int e_ones[NC], e_stab[NC], e_diff[NC];
  logic [NC-1:0] samp[REP];
  logic [NC-1:0] rm;
  logic [N-1:0] chal_m = N'(1);
  logic [N-1:0] got_chal[3];
  logic launch_prev = 1'b0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
    return {s[N-2:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction
  function automatic logic [NC-1:0] stub(input int m, input int l);
    logic b;
    b = ~l[0];
    case (m)
      0: return 2'b11;
      1: return {~b, b};
      2: return 2'b01;
      default: return NC'($urandom_range(0, 3));
    endcase
  endfunction
  function automatic logic [CW-1:0] fld(input logic [NC*CW-1:0] v, input int k);
    return v[k*CW +: CW];
  endfunction
  // PUF stub and expected-CRP producer: one new response per launch edge
  always @(negedge clk) begin
    if (puf_launch && !launch_prev) begin
      rm = stub(mode, launches);
      puf_resp = rm;
      launches++;
      samp[rep_m] = rm;
      for (int k = 0; k < NC; k++) if (rep_m > 0 && rm[k] == samp[0][k]) e_stab[k]++;
      rep_m++;
      if (rep_m == REP) begin
        cm.chal = chal_m;
        for (int k = 0; k < NC; k++) begin
          vm = 0;
          for (int i = 0; i < REP; i++) vm += int'(samp[i][k]);
          cm.resp[k] = 2 * vm > REP;
          cm.unst[k] = vm != 0 && vm != REP;
        end
        for (int k = 0; k < NC; k++) begin
          e_ones[k] += int'(cm.resp[k]);
          e_diff[k] += int'(cm.resp[k] != cm.resp[0]);
        end
        q.push_back(cm);
        chal_m = lfsr_next(chal_m);
        rep_m = 0;
      end
    end
    launch_prev = puf_launch;
  end
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (crp_valid && crp_ready) begin
      if (n_crp < 3) got_chal[n_crp] = crp_chal;
      if (q.size() == 0) check("crp_unexpected", 128'(n_crp), 128'(-1));
      else begin
        ce = q.pop_front();
        check("crp_chal", 128'(crp_chal), 128'(ce.chal));
        check("crp_resp", 128'(crp_resp), 128'(ce.resp));
        check("crp_unstable", 128'(crp_unstable), 128'(ce.unst));
      end
      n_crp++;
    end
  end
  task automatic prep(input int m);
    mode = m;
    launches = 0;
    rep_m = 0;
    chal_m = N'(1);
    for (int k = 0; k < NC; k++) begin
      e_ones[k] = 0;
      e_stab[k] = 0;
      e_diff[k] = 0;
    end
    q.delete();
    n_crp = 0;
    done_cnt = 0;
  endtask
  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
  endtask
  task automatic wait_done(input int rdy);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
      crp_ready = rdy != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (!ok) check("done_timeout", 128'(0), 128'(1));
    repeat (3) @(posedge clk);
    #1 crp_ready = 1'b1;
  endtask
  task automatic check_run(input vec_t v);
    logic [N-1:0] one;
    int lo[NC], ls[NC], ld[NC];
    one = N'(1);
    lo[0] = v.ones0; lo[1] = v.ones1;
    ls[0] = v.stab0; ls[1] = v.stab1;
    ld[0] = v.diff0; ld[1] = v.diff1;
    check("done_pulses", 128'(done_cnt), 128'(1));
    check("crp_count", 128'(n_crp), 128'(NCH));
    check("queue_empty", 128'(q.size()), 128'(0));
    check("busy_after_done", 128'(busy), 128'(0));
    for (int i = 0; i < 3; i++) check("first_chals", 128'(got_chal[i]), 128'(one << i));
    for (int k = 0; k < NC; k++) begin
      check("ones_cnt", 128'(fld(ones_cnt, k)), 128'(e_ones[k]));
      check("stable_cnt", 128'(fld(stable_cnt, k)), 128'(e_stab[k]));
      check("diff_cnt", 128'(fld(diff_cnt, k)), 128'(e_diff[k]));
      if (lo[k] >= 0) begin
        check("ones_cnt_lit", 128'(fld(ones_cnt, k)), 128'(lo[k]));
        check("stable_cnt_lit", 128'(fld(stable_cnt, k)), 128'(ls[k]));
        check("diff_cnt_lit", 128'(fld(diff_cnt, k)), 128'(ld[k]));
      end
    end
  endtask
  task automatic check_reset_outs(input string name);
    check(name, 128'({busy, done, puf_launch, crp_valid, crp_resp, crp_unstable}), 128'(0));
    check({name, "_cnts"}, 128'({ones_cnt, stable_cnt, diff_cnt}), 128'(0));
    check({name, "_crp_chal"}, 128'(crp_chal), 128'(0));
    check({name, "_puf_chal"}, 128'(puf_chal), 128'(1));
  endtask
  initial begin
    logic [N-1:0] hold_chal;
    logic [NC-1:0] hold_resp;
    bit seen;
    vt[0] = '{0, 0, 8, 8, 32, 32, 0, 0};
    vt[1] = '{1, 0, 4, 4, 16, 16, 0, 8};
    vt[2] = '{2, 1, 8, 0, 32, 32, 0, 8};
    vt[3] = '{3, 1, -1, -1, -1, -1, -1, -1};
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b0;
    check("start_with_rst", 128'(busy), 128'(0));
    for (int t = 0; t < 4; t++) begin
      prep(vt[t].mode);
      kick();
      wait_done(vt[t].rdy);
      check_run(vt[t]);
    end
    // payload must hold and no launch may fire while the consumer stalls
    prep(0);
    crp_ready = 1'b0;
    kick();
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(posedge clk);
      #1 seen = crp_valid;
    end
    check("bp_valid_seen", 128'(seen), 128'(1));
    hold_chal = crp_chal;
    hold_resp = crp_resp;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 128'(crp_valid), 128'(1));
      check("bp_payload", 128'({crp_chal, crp_resp}), 128'({hold_chal, hold_resp}));
      check("bp_launch", 128'(puf_launch), 128'(0));
    end
    crp_ready = 1'b1;
    wait_done(0);
    check_run(vt[0]);
    // reset in SETTLE of challenge 3, with an ignored start while busy
    prep(1);
    kick();
    for (int c = 0; c < 20; c++) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_busy_ignored", 128'(busy), 128'(1));
    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(posedge clk);
      #1 seen = launches == 2 * REP + 1;
    end
    check("reach_chal3", 128'(seen), 128'(1));
    check("crps_before_rst", 128'(n_crp), 128'(2));
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outs("midrun_rst");
    rst = 1'b0;
    prep(1);
    kick();
    wait_done(0);
    check_run(vt[1]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
